// File: rtl/fifo_3w_2r_if.sv
// Port bundle for the 3-push / 2-pop FIFO: three producer lanes, two consumer
// lanes and the occupancy/status outputs.
interface fifo_3w_2r_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                  push1_en_i;
  logic                  push2_en_i;
  logic                  push3_en_i;
  logic [DATA_WIDTH-1:0] data1_i;
  logic [DATA_WIDTH-1:0] data2_i;
  logic [DATA_WIDTH-1:0] data3_i;
  logic                  pop1_en_i;
  logic                  pop2_en_i;
  logic [DATA_WIDTH-1:0] data1_o;
  logic [DATA_WIDTH-1:0] data2_o;
  logic                  valid1_o;
  logic                  valid2_o;
  logic [CW-1:0]         count_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  space3_o;
  logic                  push_err_o;
  logic                  pop_err_o;

  modport master (
    output push1_en_i, push2_en_i, push3_en_i,
    output data1_i, data2_i, data3_i,
    output pop1_en_i, pop2_en_i,
    input  data1_o, data2_o, valid1_o, valid2_o, count_o,
    input  full_o, empty_o, space3_o, push_err_o, pop_err_o
  );

  modport slave (
    input  push1_en_i, push2_en_i, push3_en_i,
    input  data1_i, data2_i, data3_i,
    input  pop1_en_i, pop2_en_i,
    output data1_o, data2_o, valid1_o, valid2_o, count_o,
    output full_o, empty_o, space3_o, push_err_o, pop_err_o
  );
endinterface

// File: rtl/fifo_3w_2r.sv
// Circular FIFO taking up to three compacted pushes and two in-order pops per
// clock; the two oldest entries are presented combinationally.
module fifo_3w_2r #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input logic         clk,
  input logic         rst,
  fifo_3w_2r_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         head_q, head_d;
  logic [AW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_err_q, push_err_d;
  logic                  pop_err_q, pop_err_d;

  logic [CW-1:0]         n_push, n_pop, n_push_acc, n_pop_acc, free;
  logic                  push_ok, pop_ok;
  logic [2:0]            wr_en;
  logic [AW-1:0]         wr_addr [3];
  logic [DATA_WIDTH-1:0] wr_data [3];
  logic [AW-1:0]         head_p1;

  always_comb begin
    n_push     = CW'(bus.push1_en_i) + CW'(bus.push2_en_i) + CW'(bus.push3_en_i);
    n_pop      = CW'(bus.pop1_en_i) + CW'(bus.pop1_en_i & bus.pop2_en_i);
    free       = CW'(DEPTH) - count_q;
    // Legality uses start-of-cycle occupancy only: no pop credit, no bypass.
    push_ok    = (n_push <= free);
    pop_ok     = (bus.pop1_en_i | ~bus.pop2_en_i) && (n_pop <= count_q);
    n_push_acc = push_ok ? n_push : '0;
    n_pop_acc  = pop_ok ? n_pop : '0;

    // Each enabled lane lands after the enabled lanes ahead of it.
    wr_addr[0] = tail_q;
    wr_addr[1] = tail_q + AW'(bus.push1_en_i);
    wr_addr[2] = tail_q + AW'(bus.push1_en_i) + AW'(bus.push2_en_i);
    wr_data[0] = bus.data1_i;
    wr_data[1] = bus.data2_i;
    wr_data[2] = bus.data3_i;
    wr_en      = {bus.push3_en_i, bus.push2_en_i, bus.push1_en_i}
                 & {3{push_ok & ~rst}};

    tail_d     = tail_q + n_push_acc[AW-1:0];
    head_d     = head_q + n_pop_acc[AW-1:0];
    count_d    = count_q + n_push_acc - n_pop_acc;
    push_err_d = ~push_ok;
    pop_err_d  = ~pop_ok;

    if (rst) begin
      tail_d     = '0;
      head_d     = '0;
      count_d    = '0;
      push_err_d = 1'b0;
      pop_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    head_q     <= head_d;
    tail_q     <= tail_d;
    count_q    <= count_d;
    push_err_q <= push_err_d;
    pop_err_q  <= pop_err_d;
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 3; i++) begin
      if (wr_en[i]) mem_q[wr_addr[i]] <= wr_data[i];
    end
  end

  assign head_p1        = head_q + AW'(1);
  assign bus.valid1_o   = (count_q != '0);
  assign bus.valid2_o   = (count_q >= CW'(2));
  assign bus.data1_o    = bus.valid1_o ? mem_q[head_q] : '0;
  assign bus.data2_o    = bus.valid2_o ? mem_q[head_p1] : '0;
  assign bus.count_o    = count_q;
  assign bus.full_o     = (count_q == CW'(DEPTH));
  assign bus.empty_o    = (count_q == '0);
  assign bus.space3_o   = (free >= CW'(3));
  assign bus.push_err_o = push_err_q;
  assign bus.pop_err_o  = pop_err_q;
endmodule

// File: tb/tb_fifo_3w_2r.sv
// Self-checking bench for fifo_3w_2r: directed scenarios plus random traffic,
// compared against a queue-based reference model.
module tb_fifo_3w_2r;
  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_3w_2r_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();

  fifo_3w_2r #(.DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] q [$];
  logic          exp_push_err = 1'b0;
  logic          exp_pop_err  = 1'b0;
  int            n_checks = 0;
  int            n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    sz = q.size();
    check_eq("count", 64'(bus.count_o), 64'(sz));
    check_eq("empty", 64'(bus.empty_o), 64'(sz == 0));
    check_eq("full", 64'(bus.full_o), 64'(sz == int'(DEP)));
    check_eq("valid1", 64'(bus.valid1_o), 64'(sz >= 1));
    check_eq("valid2", 64'(bus.valid2_o), 64'(sz >= 2));
    check_eq("space3", 64'(bus.space3_o), 64'(int'(DEP) - sz >= 3));
    check_eq("data1", 64'(bus.data1_o), (sz >= 1) ? 64'(q[0]) : 64'(0));
    check_eq("data2", 64'(bus.data2_o), (sz >= 2) ? 64'(q[1]) : 64'(0));
    check_eq("push_err", 64'(bus.push_err_o), 64'(exp_push_err));
    check_eq("pop_err", 64'(bus.pop_err_o), 64'(exp_pop_err));
  endtask

  // Apply one cycle of requests, advance the model by the same rules, check.
  task automatic step(input logic r, input logic p1, input logic p2, input logic p3,
                      input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c,
                      input logic o1, input logic o2);
    int  n_push, n_pop;
    bit  push_ok, pop_ok;
    rst            = r;
    bus.push1_en_i = p1;
    bus.push2_en_i = p2;
    bus.push3_en_i = p3;
    bus.data1_i    = a;
    bus.data2_i    = b;
    bus.data3_i    = c;
    bus.pop1_en_i  = o1;
    bus.pop2_en_i  = o2;
    n_push  = int'(p1) + int'(p2) + int'(p3);
    n_pop   = o1 ? (o2 ? 2 : 1) : 0;
    push_ok = (n_push <= int'(DEP) - q.size());
    pop_ok  = !(o2 && !o1) && (n_pop <= q.size());
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      exp_push_err = 1'b0;
      exp_pop_err  = 1'b0;
    end else begin
      if (pop_ok) repeat (n_pop) void'(q.pop_front());
      if (push_ok) begin
        if (p1) q.push_back(a);
        if (p2) q.push_back(b);
        if (p3) q.push_back(c);
      end
      exp_push_err = !push_ok;
      exp_pop_err  = !pop_ok;
    end
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.push1_en_i = 1'b0; bus.push2_en_i = 1'b0; bus.push3_en_i = 1'b0;
    bus.data1_i = '0; bus.data2_i = '0; bus.data3_i = '0;
    bus.pop1_en_i = 1'b0; bus.pop2_en_i = 1'b0;
    do_reset();
    do_reset();

    // Triple push then double pop
    step(0, 1, 1, 1, 32'hA, 32'hB, 32'hC, 0, 0);
    step(0, 0, 0, 0, '0, '0, '0, 1, 1);
    idle();
    step(0, 0, 0, 0, '0, '0, '0, 1, 0);

    // Sparse push: lanes 1 and 3 only
    step(0, 1, 0, 1, 32'h11, 32'h22, 32'h33, 0, 0);
    check_eq("sparse_d2", 64'(bus.data2_o), 64'h33);
    step(0, 0, 0, 0, '0, '0, '0, 1, 1);

    // Fill to DEPTH, then push1 with pop1+pop2
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 1, 1, 1, 32'(3*i), 32'(3*i+1), 32'(3*i+2), 0, 0);
    step(0, 1, 0, 0, 32'd15, '0, '0, 0, 0);
    check_eq("full_before", 64'(bus.full_o), 64'd1);
    step(0, 1, 0, 0, 32'hDEAD, '0, '0, 1, 1);
    check_eq("full_cnt14", 64'(bus.count_o), 64'd14);
    idle();

    // Wrap: move both pointers to 14, then push across the boundary
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, $urandom, $urandom, $urandom, 0, 0);
    step(0, 1, 1, 0, $urandom, $urandom, '0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, '0, '0, '0, 1, 1);
    step(0, 1, 1, 1, 32'h1, 32'h2, 32'h3, 0, 0);
    step(0, 1, 1, 1, 32'h4, 32'h5, 32'h6, 1, 1);
    check_eq("wrap_d1", 64'(bus.data1_o), 64'h3);
    step(0, 0, 0, 0, '0, '0, '0, 1, 1);
    step(0, 0, 0, 0, '0, '0, '0, 1, 1);

    // Empty FIFO errors, and count-1 double pop
    do_reset();
    step(0, 0, 0, 0, '0, '0, '0, 0, 1);
    step(0, 1, 0, 0, 32'h77, '0, '0, 1, 0);
    check_eq("empty_push_pop_d1", 64'(bus.data1_o), 64'h77);
    step(0, 0, 0, 0, '0, '0, '0, 1, 1);
    idle();

    // Reset mid-operation while pushing
    step(0, 1, 1, 1, 32'h51, 32'h52, 32'h53, 0, 0);
    step(0, 1, 0, 0, 32'h54, '0, '0, 0, 0);
    step(1, 1, 1, 1, 32'h61, 32'h62, 32'h63, 1, 0);
    check_eq("rst_data1", 64'(bus.data1_o), 64'd0);
    idle();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic p1, p2, p3, o1, o2;
      p1 = ($urandom_range(0, 99) < 45);
      p2 = ($urandom_range(0, 99) < 35);
      p3 = ($urandom_range(0, 99) < 25);
      o1 = ($urandom_range(0, 99) < 60);
      o2 = ($urandom_range(0, 99) < (o1 ? 50 : 5));
      step((i % 211) == 210, p1, p2, p3, $urandom, $urandom, $urandom, o1, o2);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo_3w_2r.md
# fifo_3w_2r

Multi-ported circular FIFO that accepts up to three pushes and retires up to two pops per clock. It is the counterpart to the single-entry 2-write/3-read flop: here three producers write and two consumers read. It buffers completed-instruction tags between the three execution writeback ports and the 2-wide in-order retire stage of the out-of-order core. Each cycle's pushes are compacted into consecutive slots in port order, and the two oldest entries are always visible combinationally.

## Interface
- DATA_WIDTH, 32, width of each entry
- DEPTH, 16, number of entries; power of two, minimum 4
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- push1_en_i / push2_en_i / push3_en_i  in  1 each  push requests, priority order 1 > 2 > 3
- data1_i / data2_i / data3_i  in  DATA_WIDTH each  push data paired with push1..3
- pop1_en_i  in  1  retire oldest entry
- pop2_en_i  in  1  retire second-oldest entry; legal only together with pop1_en_i
- data1_o  out  DATA_WIDTH  oldest entry, or 0 when count_o < 1
- data2_o  out  DATA_WIDTH  second-oldest entry, or 0 when count_o < 2
- valid1_o / valid2_o  out  1 each  count_o >= 1 / count_o >= 2
- count_o  out  $clog2(DEPTH)+1  current occupancy
- full_o / empty_o  out  1 each  count_o == DEPTH / count_o == 0
- space3_o  out  1  DEPTH - count_o >= 3, so any push pattern is legal this cycle
- push_err_o / pop_err_o  out  1 each  one-cycle registered error pulses

## Operation
- State: mem[DEPTH], head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, and count.
- n_push = push1_en_i + push2_en_i + push3_en_i, range 0..3.
- n_pop = pop1_en_i + (pop1_en_i & pop2_en_i), range 0..2.
- Push compaction: enabled ports are written to tail, tail+1 and so on in port order, skipping disabled ports.
  - Example: push1 and push3 only → data1_i to slot tail, data3_i to slot tail+1.
- Push legality: n_push <= DEPTH - count, using the count at the start of the cycle. Same-cycle pops give no credit.
- Illegal push: the whole push group is dropped atomically; tail and mem are unchanged; push_err_o pulses the next cycle.
- Pop legality: n_pop <= count at the start of the cycle, and pop2_en_i must not be asserted without pop1_en_i. There is no push-to-pop bypass.
- Illegal pop: the whole pop is dropped; head is unchanged; pop_err_o pulses the next cycle.
- A legal push group and a legal pop group are evaluated independently within a cycle. Either can be accepted while the other is rejected.
- Update on accepted groups:
  - tail += n_push_acc
  - head += n_pop_acc
  - count += n_push_acc − n_pop_acc
- Read side is combinational from registered state:
  - data1_o = mem[head]
  - data2_o = mem[head+1 mod DEPTH]
  - Each is gated to 0 when its valid is low.
- mem contents are not reset; output gating hides stale data.

## Timing
- Reset: head = tail = count = 0.
  - empty_o = 1, space3_o = 1.
  - full_o, valid1_o, valid2_o, push_err_o, pop_err_o = 0.
  - data1_o = data2_o = 0.
- rst asserted mid-operation discards all entries at the next edge; same-cycle push and pop requests are ignored.
- Push-to-visible latency is 1 cycle: an entry pushed at edge N appears on data1_o/data2_o (if it is among the two oldest) in the cycle after edge N.
- A pop at edge N advances the outputs in the cycle after edge N. Consumers sample data*_o in the same cycle they assert pop*_en_i.
- Error pulses are high for exactly one cycle after the offending edge, and are not sticky.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. A 3-push starting at slot DEPTH-2 writes slots DEPTH-2, DEPTH-1, 0.
- Full with a simultaneous 2-pop and 1-push: the pop is accepted and the push is rejected, so count = DEPTH-2 and push_err_o = 1.
- Empty with a simultaneous push and pop: the pop is rejected and the push is accepted, so count = n_push and pop_err_o = 1.
- Count 1 with pop1 + pop2: the whole pop is rejected, count stays 1, and pop_err_o = 1.

## Test plan
- Reset, then push1 + push2 + push3 with data 0xA, 0xB, 0xC:
  - Same cycle: valid1_o = 0.
  - Next cycle: count_o = 3, data1_o = 0xA, data2_o = 0xB.
  - Pop1 + pop2: next cycle data1_o = 0xC, valid2_o = 0, count_o = 1.
- Sparse push, push1 = 0x11 and push3 = 0x33 only → data1_o = 0x11, data2_o = 0x33, count_o = 2.
- Fill to DEPTH (16), then push1 + pop1 + pop2:
  - full_o = 1 before the cycle.
  - Next cycle: count_o = 14, push_err_o = 1 for one cycle, pop_err_o = 0.
- Wrap: advance head and tail to 14, push 3 entries (0x1, 0x2, 0x3), then pop 2/cycle → sequence 0x1, 0x2, 0x3 in order; tail = 1.
- Empty FIFO:
  - pop2_en_i alone → pop_err_o = 1, count_o = 0.
  - push1 + pop1 in the same cycle → count_o = 1, pop_err_o = 1, data1_o = pushed value.
- Assert rst with count_o = 5 while pushing 3 → next cycle count_o = 0, empty_o = 1, data1_o = 0, no error pulses.
